// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// This module resolves conditional branches in the execute stage and predicts
// them at fetch. Prediction uses a PC-indexed table of 2-bit saturating
// counters, and each legal resolve trains that table.
//
// Ports
//   clk, rstN       rising-edge clock, asynchronous active-low reset
//   fetch_valid     lookup request; fetch_pc selects the counter
//   pred_valid      registered lookup-valid, one cycle after fetch_valid
//   pred_taken      registered MSB of the looked-up counter
//   ex_valid/branch resolve request (both high); funct3 selects the compare
//   ex_pc           PC of the resolving branch, selects the counter to train
//   ex_rs1/ex_rs2   compare operands
//   ex_pred_taken   prediction that travelled down the pipe with the branch
//   branchType      funct3 on a legal resolve, else 0
//   takeBranch      combinational branch outcome
//   mispredict      combinational outcome != ex_pred_taken on a legal resolve
//   illegal_br      resolve with reserved funct3 (010/011)
//   br_count        saturating count of legal resolves
//   mispred_count   saturating count of mispredicts
//
// Configuration
//   BPU_STATS_EN    when defined, the two statistics counters exist.
//                   When it is undefined, both count ports are tied to zero.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int PC_LSB = 2
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            branch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  output logic [2:0]      branchType,
  output logic            takeBranch,
  output logic            mispredict,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       r_table [DEPTH];
  logic             r_predValid;
  logic             r_predTaken;

  logic [IDX_W-1:0] w_fetchIdx;
  logic [IDX_W-1:0] w_exIdx;
  logic             w_resolve;
  logic             w_illegalCode;
  logic             w_legal;
  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic             w_outcome;
  logic             w_unusedPcBits;

  assign w_fetchIdx = fetch_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign w_exIdx    = ex_pc[PC_LSB+IDX_W-1:PC_LSB];

  // PC bits outside the index are ignored on purpose; aliasing is allowed.
  assign w_unusedPcBits = ^{fetch_pc, ex_pc};

  // Codes 010 and 011 are reserved. They flag illegal_br and must not
  // train the table or bump the statistics.
  assign w_resolve     = ex_valid & branch;
  assign w_illegalCode = (funct3[2:1] == 2'b01);
  assign w_legal       = w_resolve & ~w_illegalCode;

  assign w_eq  = (ex_rs1 == ex_rs2);
  assign w_lt  = ($signed(ex_rs1) < $signed(ex_rs2));
  assign w_ltu = (ex_rs1 < ex_rs2);

  // funct3[0] inverts the base compare (BNE/BGE/BGEU).
  always_comb begin
    w_outcome = 1'b0;
    case (funct3)
      3'b000:  w_outcome = w_eq;
      3'b001:  w_outcome = ~w_eq;
      3'b100:  w_outcome = w_lt;
      3'b101:  w_outcome = ~w_lt;
      3'b110:  w_outcome = w_ltu;
      3'b111:  w_outcome = ~w_ltu;
      default: w_outcome = 1'b0;
    endcase
  end

  assign branchType = w_legal ? funct3 : 3'b000;
  assign takeBranch = w_legal & w_outcome;
  assign mispredict = w_legal & (w_outcome != ex_pred_taken);
  assign illegal_br = w_resolve & w_illegalCode;

  // Counter table. Reset sets every entry to weakly-not-taken.
  // Training saturates at both ends.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= 2'b01;
      end
    end else if (w_legal) begin
      if (w_outcome) begin
        if (r_table[w_exIdx] != 2'b11) begin
          r_table[w_exIdx] <= r_table[w_exIdx] + 2'd1;
        end
      end else begin
        if (r_table[w_exIdx] != 2'b00) begin
          r_table[w_exIdx] <= r_table[w_exIdx] - 2'd1;
        end
      end
    end
  end

  // The lookup samples the table before this edge's training lands.
  // A same-index lookup and update therefore returns the old counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_predValid <= 1'b0;
      r_predTaken <= 1'b0;
    end else begin
      r_predValid <= fetch_valid;
      if (fetch_valid) begin
        r_predTaken <= r_table[w_fetchIdx][1];
      end
    end
  end

  assign pred_valid = r_predValid;
  assign pred_taken = r_predTaken;

`ifdef BPU_STATS_EN
  logic [31:0] r_brCount;
  logic [31:0] r_mispredCount;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_brCount      <= 32'h0;
      r_mispredCount <= 32'h0;
    end else if (w_legal) begin
      if (r_brCount != 32'hFFFF_FFFF) begin
        r_brCount <= r_brCount + 32'd1;
      end
      if (mispredict && (r_mispredCount != 32'hFFFF_FFFF)) begin
        r_mispredCount <= r_mispredCount + 32'd1;
      end
    end
  end

  assign br_count      = r_brCount;
  assign mispred_count = r_mispredCount;
`else
  assign br_count      = 32'h0;
  assign mispred_count = 32'h0;
`endif

endmodule
